// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: captures, shifts (MSB first, two-phase clk1/clk2) and updates a serial chain.
// Optional running parity of the shifted-out bits is built only when SCAN_CTRL_PARITY_EN is defined.
`timescale 1ns/1ps
module scan_chain_ctrl #(
    parameter int NUM_SCAN_BITS = 523
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [NUM_SCAN_BITS-1:0] wr_data,
    input  logic                     abort,
    output logic [NUM_SCAN_BITS-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rd_parity,
    output logic                     sc_clk1,
    output logic                     sc_clk2,
    output logic                     sc_scan_in,
    output logic                     sc_update,
    output logic                     sc_capture,
    input  logic                     sc_scan_out
);

    localparam int CNT_W = (NUM_SCAN_BITS > 1) ? $clog2(NUM_SCAN_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_SCAN_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CAPT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_UPDT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [1:0]               phase_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic                     upd_q;
    logic                     samp_q;
    logic [NUM_SCAN_BITS-1:0] shreg_q;
    logic [NUM_SCAN_BITS-1:0] shreg_shift;
    logic                     accept;
    logic                     slot_end;
    logic                     last_bit;
    logic                     load_rd;
    logic                     in_slot;

    assign cmd_ready   = (state_q == S_IDLE);
    assign accept      = cmd_valid && cmd_ready && !abort;
    assign slot_end    = (phase_q == 2'd3);
    assign last_bit    = (bit_cnt_q == LAST_BIT);
    // One register serves both directions: the MSB drives the chain, the bit
    // sampled at k0 enters at the LSB when the slot ends.
    assign shreg_shift = {shreg_q[NUM_SCAN_BITS-2:0], samp_q};
    assign load_rd     = (state_d == S_DONE) && (state_q != S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cmd_op[0] ? S_CAPT : S_SHIFT;
            S_CAPT:  if (slot_end) state_d = S_SHIFT;
            S_SHIFT: if (slot_end && last_bit) state_d = upd_q ? S_UPDT : S_DONE;
            S_UPDT:  if (phase_q[0]) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            bit_cnt_q <= '0;
            rd_data   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q != S_IDLE) &&
                (state_d == S_CAPT || state_d == S_SHIFT || state_d == S_UPDT))
                phase_q <= phase_q + 2'd1;
            else
                phase_q <= 2'd0;
            if (accept)
                bit_cnt_q <= '0;
            else if ((state_q == S_SHIFT) && slot_end)
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            if (load_rd)
                rd_data <= (state_q == S_SHIFT) ? shreg_shift : shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg_q <= wr_data;
            upd_q   <= cmd_op[1];
        end else if (state_q == S_SHIFT) begin
            if (phase_q == 2'd0) samp_q  <= sc_scan_out;
            if (slot_end)        shreg_q <= shreg_shift;
        end
    end

`ifdef SCAN_CTRL_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst || accept)
            par_q <= 1'b0;
        else if ((state_q == S_SHIFT) && (phase_q == 2'd0))
            par_q <= par_q ^ sc_scan_out;
    end

    assign rd_parity = par_q;
`else
    assign rd_parity = 1'b0;
`endif

    assign in_slot    = (state_q == S_CAPT) || (state_q == S_SHIFT);
    assign sc_clk1    = in_slot && (phase_q == 2'd1);
    assign sc_clk2    = in_slot && (phase_q == 2'd3);
    assign sc_capture = (state_q == S_CAPT);
    assign sc_update  = (state_q == S_UPDT);
    assign sc_scan_in = (state_q == S_SHIFT) && shreg_q[NUM_SCAN_BITS-1];
    assign rd_valid   = (state_q == S_DONE);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl: an 8-bit instance with a two-latch chain model,
// plus a default-length instance for the long-chain latency and update check.
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 8-bit instance
    logic       v_s = 0, ab_s = 0, rdy_s, rv_s, rp_s;
    logic [1:0] op_s = 0;
    logic [7:0] wr_s = 0, rd_s;
    logic       c1_s, c2_s, si_s, up_s, cp_s, so_s;

    scan_chain_ctrl #(.NUM_SCAN_BITS(8)) dut_s (
        .clk(clk), .rst(rst), .cmd_valid(v_s), .cmd_ready(rdy_s), .cmd_op(op_s),
        .wr_data(wr_s), .abort(ab_s), .rd_data(rd_s), .rd_valid(rv_s), .rd_parity(rp_s),
        .sc_clk1(c1_s), .sc_clk2(c2_s), .sc_scan_in(si_s), .sc_update(up_s),
        .sc_capture(cp_s), .sc_scan_out(so_s)
    );

    // Default-length instance
    logic         v_l = 0, ab_l = 0, rdy_l, rv_l, rp_l;
    logic [1:0]   op_l = 0;
    logic [522:0] wr_l = '0, rd_l;
    logic         c1_l, c2_l, si_l, up_l, cp_l, so_l;

    scan_chain_ctrl dut_l (
        .clk(clk), .rst(rst), .cmd_valid(v_l), .cmd_ready(rdy_l), .cmd_op(op_l),
        .wr_data(wr_l), .abort(ab_l), .rd_data(rd_l), .rd_valid(rv_l), .rd_parity(rp_l),
        .sc_clk1(c1_l), .sc_clk2(c2_l), .sc_scan_in(si_l), .sc_update(up_l),
        .sc_capture(cp_l), .sc_scan_out(so_l)
    );

    // Chain models: clk1 loads the L1 latches (parallel input when capturing), clk2 moves L1 to L2
    logic [7:0]   par_s = 8'h3C, l1_s = '0, chain_s = 8'h5A, upd_s = '0;
    logic [522:0] par_l = '0, l1_l = '0, chain_l = '0, upd_l = '0;

    always @(posedge clk) begin
        if (c1_s) l1_s <= cp_s ? par_s : {chain_s[6:0], si_s};
        if (c2_s) chain_s <= l1_s;
        if (up_s) upd_s <= chain_s;
        if (c1_l) l1_l <= cp_l ? par_l : {chain_l[521:0], si_l};
        if (c2_l) chain_l <= l1_l;
        if (up_l) upd_l <= chain_l;
    end
    assign so_s = chain_s[7];
    assign so_l = chain_l[522];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [522:0] got, input logic [522:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rd;
        logic [7:0] wr;
        logic [1:0] op;
        int         acc;
    } ent_t;

    ent_t       sb[$];
    logic [7:0] exp_chain = 8'h5A;

    // Per-command observations of the 8-bit instance, cleared at each accept
    int         n_clk1 = 0, n_clk2 = 0, n_upd = 0, rdy_hi = 0, ovl_s = 0, ovl_l = 0;
    logic [7:0] ser = '0;
    ent_t       e;

    always @(negedge clk) begin
        if (c1_s && c2_s) ovl_s++;
        if (c1_l && c2_l) ovl_l++;
        n_clk1 += int'(c1_s);
        n_clk2 += int'(c2_s);
        n_upd  += int'(up_s);
        if (c1_s && !cp_s) ser = {ser[6:0], si_s};
        if (rdy_s) rdy_hi++;
        if (rv_s) begin
            if (sb.size() == 0) begin
                check("spurious_rd_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_s, e.rd);
                check("latency", cyc - e.acc, 1 + 4 * int'(e.op[0]) + 32 + 2 * int'(e.op[1]));
`ifdef SCAN_CTRL_PARITY_EN
                check("rd_parity", rp_s, ^e.rd);
`else
                check("rd_parity", rp_s, 0);
`endif
                check("clk1_pulses", n_clk1, 8 + int'(e.op[0]));
                check("clk2_pulses", n_clk2, 8 + int'(e.op[0]));
                check("update_cycles", n_upd, 2 * int'(e.op[1]));
                check("serial_in", ser, e.wr);
                check("ready_while_busy", rdy_hi, 0);
                if (e.op[1]) check("chain_update", upd_s, e.wr);
            end
        end
        if (!rst && v_s && rdy_s && !ab_s) begin
            n_clk1 = 0; n_clk2 = 0; n_upd = 0; rdy_hi = 0; ser = '0;
        end
    end

    task automatic send_s(input logic [1:0] op, input logic [7:0] wr, input bit push, output int acc);
        int   n;
        ent_t x;
        n = 0;
        @(posedge clk); #1;
        v_s = 1'b1; op_s = op; wr_s = wr;
        @(negedge clk);
        while (!rdy_s && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 3000, 1);
        acc = cyc;
        if (push) begin
            x.rd = op[0] ? par_s : exp_chain;
            x.wr = wr; x.op = op; x.acc = acc;
            sb.push_back(x);
            exp_chain = wr;
        end
        @(posedge clk); #1;
        v_s = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", rdy_s, 1);
        check("reset_sc", {c1_s, c2_s, si_s, up_s, cp_s}, 0);
        check("reset_rd_data", rd_s, 0);
        check("reset_rd_valid", rv_s, 0);
        check("reset_parity", rp_s, 0);
        check("reset_ready_l", rdy_l, 1);

        // Update only, chain preloaded with 5A
        send_s(2'b10, 8'hA5, 1, acc);
        drain();
        // Capture only
        send_s(2'b01, 8'hC3, 1, acc);
        drain();
        // Back-to-back: second command held while the first is busy
        send_s(2'b11, 8'hFF, 1, acc);
        send_s(2'b00, 8'h00, 1, acc);
        drain();

        // abort together with cmd_valid in IDLE must not accept
        @(posedge clk); #1;
        v_s = 1'b1; ab_s = 1'b1; op_s = 2'b11;
        @(posedge clk); #1;
        v_s = 1'b0; ab_s = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", rdy_s, 1);
        check("abort_idle_sc", {c1_s, c2_s, si_s, up_s, cp_s}, 0);

        // abort at shift slot 3, phase k1
        send_s(2'b00, 8'h96, 0, acc);
        repeat (13) @(posedge clk);
        #1 ab_s = 1'b1;
        @(negedge clk);
        check("abort_at_k1", c1_s, 1);
        @(posedge clk); #1 ab_s = 1'b0;
        @(negedge clk);
        check("abort_sc_low", {c1_s, c2_s, si_s, up_s, cp_s}, 0);
        check("abort_no_valid", rv_s, 0);
        @(negedge clk);
        check("abort_ready", rdy_s, 1);
        repeat (20) @(negedge clk);

        par_s = 8'hE7;
        send_s(2'b01, 8'h42, 1, acc);
        drain();

        // rst during the first UPDT cycle
        send_s(2'b10, 8'h99, 0, acc);
        repeat (32) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("update_before_rst", up_s, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sc_update", up_s, 0);
        check("rst_rd_data", rd_s, 0);
        check("rst_rd_valid", rv_s, 0);
        check("rst_parity", rp_s, 0);
        check("rst_ready", rdy_s, 1);

        par_s = 8'h24;
        send_s(2'b11, 8'h5B, 1, acc);
        drain();
        send_s(2'b00, 8'h11, 1, acc);
        drain();

        // Default-length chain, capture and update
        for (int i = 0; i < 523; i++) par_l[i] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        v_l = 1'b1; op_l = 2'b11;
        for (int i = 0; i < 523; i++) wr_l[i] = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("ready_l", rdy_l, 1);
        acc = cyc;
        @(posedge clk); #1 v_l = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rv_l && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_l", n < 3000, 1);
        check("latency_l", cyc - acc, 1 + 4 + 4 * 523 + 2);
        check("rd_data_l", rd_l, par_l);
        check("chain_update_l", upd_l, wr_l);
`ifdef SCAN_CTRL_PARITY_EN
        check("rd_parity_l", rp_l, ^par_l);
`else
        check("rd_parity_l", rp_l, 0);
`endif
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        check("clk_overlap_s", ovl_s, 0);
        check("clk_overlap_l", ovl_l, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
